cell_draw_sequencer: RTL and testbench
======================================

Name: cell_draw_sequencer

Overview:
Parametrised painter scheduler that sits between gamelogic and the box painter (kick/busy/done handshake).
- Redraws a multi-cell piece of N_CELLS cells: erase the previous footprint in background colour, then draw the new footprint in piece colour.
- Performs a full-board background clear on request.
- Queues requests that arrive while a pass is running, so the painter never sees overlapping kicks.

Parameters:
N_CELLS, 4, cells per piece footprint
XW, 4, board column index width
YW, 5, board row index width
BOARD_W, 10, board columns
BOARD_H, 20, board rows
CELL_PX_W, 64, cell pitch in pixels, horizontal
CELL_PX_H, 24, cell pitch in pixels, vertical
X_ORIGIN, 0, pixel x of board column 0
Y_ORIGIN, 0, pixel y of board row 0
COLOR_W, 9, colour width (3:3:3)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
cur_x  in  N_CELLS*XW  packed column of each current cell; cell i at [i*XW +: XW]
cur_y  in  N_CELLS*YW  packed row of each current cell
piece_color  in  COLOR_W  draw colour
bg_color  in  COLOR_W  erase/clear colour
redraw_req  in  1  one-cycle request to repaint the piece
clear_req  in  1  one-cycle request to clear the board, then draw the piece
kick  out  1  one-cycle start to painter
x0  out  10  box pixel x
y0  out  9  box pixel y
paint_color  out  COLOR_W  box colour
busy  in  1  painter busy
done  in  1  painter one-cycle completion pulse
idle  out  1  high in IDLE with nothing pending
frame_done  out  1  one-cycle pulse when a pass commits

Behaviour:
Reset values:
- kick=0, x0=0, y0=0, paint_color=0, frame_done=0, idle=1.
- prev_valid=0, pend_redraw=0, pend_clear=0, all indices 0.
- Reset mid-pass aborts immediately; no further kicks are issued.

Request latching:
- redraw_req or clear_req arriving in any state sets pend_redraw or pend_clear.
- Multiple pending redraws coalesce into one.
- idle = (state==IDLE) & ~pend_redraw & ~pend_clear.

States: IDLE, CLR_ISSUE, CLR_WAIT, ERS_ISSUE, ERS_WAIT, DRW_ISSUE, DRW_WAIT, COMMIT.

IDLE:
- pend_clear takes priority. It clears pend_clear and pend_redraw, sets row=col=0, and enters CLR_ISSUE.
- Otherwise pend_redraw clears pend_redraw, snapshots cur_x/cur_y into snap, and enters ERS_ISSUE, or DRW_ISSUE when prev_valid=0.
- Snapshot taken in the same cycle as leaving IDLE; input changes after that do not affect the pass.

Any *_ISSUE state:
- Waits for busy=0.
- Then drives x0, y0 and paint_color, asserts kick for exactly one cycle, and enters the matching *_WAIT.

Any *_WAIT state:
- Waits for done=1; kick stays 0.

CLR:
- Box at (col,row) in bg_color, row-major.
- After the box at col=BOARD_W-1, row=BOARD_H-1 completes: snapshot the cells, go to DRW_ISSUE.
- After a clear, no erase of the previous footprint is performed.

ERS:
- Erases prev cell k, k=0..N_CELLS-1, in bg_color.
- After the last cell, go to DRW_ISSUE with k=0.

DRW:
- Draws snap cell k in piece_color.
- After the last cell, go to COMMIT.

COMMIT (one cycle):
- prev <= snap, prev_valid <= 1, frame_done=1, then IDLE.

Coordinate arithmetic:
- x0 = X_ORIGIN + col*CELL_PX_W; y0 = Y_ORIGIN + row*CELL_PX_H.
- Computed at full width, then truncated to 10/9 bits.
- Constant multiply only; no runtime multiplier required.

Boundaries:
- A cell with col>=BOARD_W or row>=BOARD_H is skipped: no kick, index advances next cycle. This applies to both erase and draw.
- Duplicate cells within one footprint are each painted.
- Requests arriving during a pass are serviced after COMMIT; pend_clear still has priority.

Throughput:
- Minimum 2 cycles per box plus painter time.

Optional Feature:
SKIP_OVERLAP_EN.
- Defined: in ERS, a prev cell equal to any snap cell is skipped (no kick), which removes flicker on overlap. If every prev cell overlaps, zero erase kicks are issued.
- Undefined: all N_CELLS prev cells are erased unconditionally.

Test Plan:
1. Reset, then redraw_req with cells (4,0)(5,0)(4,1)(5,1); painter done 3 cycles after each kick.
   -> exactly 4 kicks, magenta, x0=256,320,256,320 and y0=0,0,24,24; then one frame_done; no erase.
2. Repeat with every row+1.
   -> 4 erase kicks in bg at the old boxes, then 4 draw kicks at y0=24,24,48,48.
   -> With SKIP_OVERLAP_EN: 2 erase kicks only, at (4,0) and (5,0).
3. clear_req.
   -> 200 bg kicks, the last at x0=576, y0=456; then 4 draw kicks; then frame_done.
4. Three redraw_req pulses during a draw pass.
   -> exactly one additional pass after COMMIT.
   -> clear_req together with redraw_req in IDLE -> clear pass only, ending in a draw.
5. Hold busy=1 for 50 cycles in DRW_ISSUE.
   -> kick stays 0, then fires one cycle after busy falls.
   -> A cell at col=12 -> no kick for that cell.
6. Assert reset during ERS_WAIT.
   -> next cycle kick=0, idle=1, prev_valid=0; the next redraw_req draws with no erase.

Source files
------------

// File: rtl/cell_draw_sequencer.sv
// Painter scheduler: clears the board and erases/redraws a multi-cell piece as a series of box kicks.
// Define SKIP_OVERLAP_EN to skip erasing previous cells that the new footprint repaints anyway.
module cell_draw_sequencer #(
    parameter int N_CELLS   = 4,
    parameter int XW        = 4,
    parameter int YW        = 5,
    parameter int BOARD_W   = 10,
    parameter int BOARD_H   = 20,
    parameter int CELL_PX_W = 64,
    parameter int CELL_PX_H = 24,
    parameter int X_ORIGIN  = 0,
    parameter int Y_ORIGIN  = 0,
    parameter int COLOR_W   = 9
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [N_CELLS*XW-1:0] cur_x,
    input  logic [N_CELLS*YW-1:0] cur_y,
    input  logic [COLOR_W-1:0]    piece_color,
    input  logic [COLOR_W-1:0]    bg_color,
    input  logic                  redraw_req,
    input  logic                  clear_req,
    output logic                  kick,
    output logic [9:0]            x0,
    output logic [8:0]            y0,
    output logic [COLOR_W-1:0]    paint_color,
    input  logic                  busy,
    input  logic                  done,
    output logic                  idle,
    output logic                  frame_done
);
    localparam int KW = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(N_CELLS - 1);
    localparam logic [XW-1:0] COL_LAST = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(BOARD_H - 1);

    typedef enum logic [2:0] {
        IDLE, CLR_ISSUE, CLR_WAIT, ERS_ISSUE, ERS_WAIT, DRW_ISSUE, DRW_WAIT, COMMIT
    } state_t;

    state_t state, state_nxt;
    logic [KW-1:0] k, k_nxt;
    logic [XW-1:0] col, col_nxt;
    logic [YW-1:0] row, row_nxt;
    logic pend_redraw, pend_clear, prev_valid;
    logic [N_CELLS-1:0][XW-1:0] snap_x, prev_x;
    logic [N_CELLS-1:0][YW-1:0] snap_y, prev_y;

    logic [XW-1:0] bx;
    logic [YW-1:0] by;
    logic [COLOR_W-1:0] bcolor;
    logic oob, overlap, kick_nxt, load_snap, commit, take_clear, take_redraw, ers_adv, drw_adv;
    int px, py;

    assign idle = (state == IDLE) & ~pend_redraw & ~pend_clear;
    assign oob  = (int'(bx) >= BOARD_W) || (int'(by) >= BOARD_H);

    // Constant-coefficient multiply; truncated to the painter's coordinate width on load.
    always_comb begin
        px = X_ORIGIN + int'(bx) * CELL_PX_W;
        py = Y_ORIGIN + int'(by) * CELL_PX_H;
    end

`ifdef SKIP_OVERLAP_EN
    always_comb begin
        overlap = 1'b0;
        for (int j = 0; j < N_CELLS; j++)
            if (prev_x[k] == snap_x[j] && prev_y[k] == snap_y[j]) overlap = 1'b1;
    end
`else
    assign overlap = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        col_nxt     = col;
        row_nxt     = row;
        kick_nxt    = 1'b0;
        load_snap   = 1'b0;
        commit      = 1'b0;
        take_clear  = 1'b0;
        take_redraw = 1'b0;
        ers_adv     = 1'b0;
        drw_adv     = 1'b0;
        bx          = '0;
        by          = '0;
        bcolor      = bg_color;
        case (state)
            IDLE: begin
                if (pend_clear) begin
                    take_clear = 1'b1;
                    col_nxt    = '0;
                    row_nxt    = '0;
                    state_nxt  = CLR_ISSUE;
                end else if (pend_redraw) begin
                    take_redraw = 1'b1;
                    load_snap   = 1'b1;
                    k_nxt       = '0;
                    state_nxt   = prev_valid ? ERS_ISSUE : DRW_ISSUE;
                end
            end
            CLR_ISSUE: begin
                bx = col;
                by = row;
                if (!busy) begin
                    kick_nxt  = 1'b1;
                    state_nxt = CLR_WAIT;
                end
            end
            CLR_WAIT: begin
                if (done) begin
                    state_nxt = CLR_ISSUE;
                    if (col != COL_LAST) begin
                        col_nxt = col + 1'b1;
                    end else begin
                        col_nxt = '0;
                        if (row != ROW_LAST) begin
                            row_nxt = row + 1'b1;
                        end else begin
                            row_nxt   = '0;
                            load_snap = 1'b1;
                            k_nxt     = '0;
                            state_nxt = DRW_ISSUE;
                        end
                    end
                end
            end
            ERS_ISSUE: begin
                bx = prev_x[k];
                by = prev_y[k];
                if (oob || overlap) ers_adv = 1'b1;
                else if (!busy) begin
                    kick_nxt  = 1'b1;
                    state_nxt = ERS_WAIT;
                end
            end
            ERS_WAIT: if (done) ers_adv = 1'b1;
            DRW_ISSUE: begin
                bx     = snap_x[k];
                by     = snap_y[k];
                bcolor = piece_color;
                if (oob) drw_adv = 1'b1;
                else if (!busy) begin
                    kick_nxt  = 1'b1;
                    state_nxt = DRW_WAIT;
                end
            end
            DRW_WAIT: if (done) drw_adv = 1'b1;
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Skipped cells and completed boxes share the same index advance.
        if (ers_adv) begin
            k_nxt     = (k == K_LAST) ? '0 : k + 1'b1;
            state_nxt = (k == K_LAST) ? DRW_ISSUE : ERS_ISSUE;
        end
        if (drw_adv) begin
            k_nxt     = (k == K_LAST) ? '0 : k + 1'b1;
            state_nxt = (k == K_LAST) ? COMMIT : DRW_ISSUE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            k           <= '0;
            col         <= '0;
            row         <= '0;
            pend_redraw <= 1'b0;
            pend_clear  <= 1'b0;
            prev_valid  <= 1'b0;
            snap_x      <= '0;
            snap_y      <= '0;
            prev_x      <= '0;
            prev_y      <= '0;
            kick        <= 1'b0;
            x0          <= '0;
            y0          <= '0;
            paint_color <= '0;
            frame_done  <= 1'b0;
        end else begin
            k           <= k_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            // A new request always wins over the consume, so late arrivals get their own pass.
            pend_clear  <= clear_req | (pend_clear & ~take_clear);
            pend_redraw <= redraw_req | (pend_redraw & ~(take_redraw | take_clear));
            kick        <= kick_nxt;
            frame_done  <= commit;
            if (kick_nxt) begin
                x0          <= 10'(px);
                y0          <= 9'(py);
                paint_color <= bcolor;
            end
            if (load_snap) begin
                snap_x <= cur_x;
                snap_y <= cur_y;
            end
            if (commit) begin
                prev_x     <= snap_x;
                prev_y     <= snap_y;
                prev_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cell_draw_sequencer.sv
// Scoreboard bench for cell_draw_sequencer; tracks SKIP_OVERLAP_EN the same way as the design build.
module tb_cell_draw_sequencer;
    localparam int N = 4, XW = 4, YW = 5, BW = 10, BH = 20;
    localparam int PXW = 64, PXH = 24, XO = 0, YO = 0, CW = 9;

    logic clk = 1'b0, reset = 1'b1;
    logic [N*XW-1:0] cur_x;
    logic [N*YW-1:0] cur_y;
    logic [CW-1:0] piece_color, bg_color, paint_color;
    logic redraw_req = 1'b0, clear_req = 1'b0;
    logic kick, busy, done, idle, frame_done;
    logic [9:0] x0;
    logic [8:0] y0;
    logic busy_p = 1'b0, busy_hold = 1'b0;

    assign busy = busy_p | busy_hold;
    always #5 clk = ~clk;

    cell_draw_sequencer dut (
        .CLOCK_50(clk), .reset(reset), .cur_x(cur_x), .cur_y(cur_y),
        .piece_color(piece_color), .bg_color(bg_color),
        .redraw_req(redraw_req), .clear_req(clear_req),
        .kick(kick), .x0(x0), .y0(y0), .paint_color(paint_color),
        .busy(busy), .done(done), .idle(idle), .frame_done(frame_done)
    );

    typedef struct { bit frame; int x; int y; int c; } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;
    int lat_lo = 2, lat_hi = 2;
    int cx[N], cy[N], mpx[N], mpy[N];
    bit mvalid = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: list of boxes a pass must paint, in order, then the commit.
    function automatic bit on_board(int x, int y);
        return (x < BW) && (y < BH);
    endfunction

    task automatic push_box(int x, int y, int c);
        exp_t e;
        e.frame = 0;
        e.x = (XO + x * PXW) % 1024;
        e.y = (YO + y * PXH) % 512;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic model_pass(bit clr);
        exp_t e;
        bit skip;
        if (clr) begin
            for (int r = 0; r < BH; r++)
                for (int c = 0; c < BW; c++) push_box(c, r, int'(bg_color));
        end else if (mvalid) begin
            for (int k = 0; k < N; k++) begin
                skip = !on_board(mpx[k], mpy[k]);
`ifdef SKIP_OVERLAP_EN
                for (int j = 0; j < N; j++)
                    if (mpx[k] == cx[j] && mpy[k] == cy[j]) skip = 1;
`endif
                if (!skip) push_box(mpx[k], mpy[k], int'(bg_color));
            end
        end
        for (int k = 0; k < N; k++)
            if (on_board(cx[k], cy[k])) push_box(cx[k], cy[k], int'(piece_color));
        e.frame = 1; e.x = 0; e.y = 0; e.c = 0;
        q.push_back(e);
        mpx = cx;
        mpy = cy;
        mvalid = 1;
    endtask

    task automatic set_cells(int x0v, int y0v, int x1v, int y1v, int x2v, int y2v, int x3v, int y3v);
        cx[0] = x0v; cy[0] = y0v; cx[1] = x1v; cy[1] = y1v;
        cx[2] = x2v; cy[2] = y2v; cx[3] = x3v; cy[3] = y3v;
        for (int i = 0; i < N; i++) begin
            cur_x[i*XW +: XW] = XW'(cx[i]);
            cur_y[i*YW +: YW] = YW'(cy[i]);
        end
    endtask

    task automatic pulse(bit r, bit c);
        redraw_req = r;
        clear_req  = c;
        @(negedge clk);
        redraw_req = 1'b0;
        clear_req  = 1'b0;
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        while (!(idle && q.size() == 0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, int'(n < 6000), 1);
        repeat (3) @(negedge clk);
        chk({nm, "_drained"}, q.size(), 0);
        chk({nm, "_idle"}, int'(idle), 1);
    endtask

    task automatic wait_kick(string nm);
        int n = 0;
        while (!kick && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_kick_timeout"}, int'(n < 500), 1);
    endtask

    // Painter model: busy from kick until a one-cycle done pulse.
    initial begin
        int lat;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (kick && !reset) begin
                busy_p = 1'b1;
                lat = $urandom_range(lat_lo, lat_hi);
                repeat (lat) @(negedge clk);
                done = 1'b1;
                @(negedge clk);
                done   = 1'b0;
                busy_p = 1'b0;
            end
        end
    end

    // Monitor: every kick or frame_done consumes the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (kick || frame_done)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got kick=%0b fd=%0b x0=%0d y0=%0d, want none",
                         kick, frame_done, x0, y0);
            end else begin
                e = q.pop_front();
                if (e.frame != frame_done || (kick && (int'(x0) != e.x || int'(y0) != e.y ||
                    int'(paint_color) != e.c))) begin
                    bad++;
                    $display("FAIL event: got kick=%0b fd=%0b x0=%0d y0=%0d col=%0h, want fd=%0b x0=%0d y0=%0d col=%0h",
                             kick, frame_done, x0, y0, paint_color, e.frame, e.x, e.y, e.c);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kicks;
        bit clr;
        piece_color = '0;
        bg_color    = '0;
        set_cells(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_kick", int'(kick), 0);
        chk("rst_x0", int'(x0), 0);
        chk("rst_y0", int'(y0), 0);
        chk("rst_color", int'(paint_color), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_idle", int'(idle), 1);
        reset = 1'b0;
        @(negedge clk);

        // First draw: no erase, magenta square.
        piece_color = 9'h1C7;
        bg_color    = 9'h000;
        set_cells(4, 0, 5, 0, 4, 1, 5, 1);
        model_pass(0);
        pulse(1, 0);
        wait_done("t1");
        chk("t1_last_x0", int'(x0), 320);
        chk("t1_last_y0", int'(y0), 24);

        // Move down one row: erase then draw.
        set_cells(4, 1, 5, 1, 4, 2, 5, 2);
        model_pass(0);
        pulse(1, 0);
        wait_done("t2");

        // Full board clear, then redraw.
        bg_color = 9'h049;
        model_pass(1);
        pulse(0, 1);
        wait_done("t3");

        // Requests during a pass coalesce into one extra pass.
        set_cells(0, 5, 1, 5, 2, 5, 3, 5);
        model_pass(0);
        pulse(1, 0);
        wait_kick("t4");
        for (int i = 0; i < 3; i++) begin
            pulse(1, 0);
            @(negedge clk);
        end
        model_pass(0);
        wait_done("t4a");
        model_pass(1);
        pulse(1, 1);
        wait_done("t4b");

        // Reset during an erase wait aborts the pass and forgets the footprint.
        set_cells(7, 10, 8, 10, 7, 11, 8, 11);
        model_pass(0);
        pulse(1, 0);
        wait_kick("t6");
        reset = 1'b1;
        q.delete();
        mvalid = 0;
        @(negedge clk);
        chk("t6_kick", int'(kick), 0);
        chk("t6_idle", int'(idle), 1);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Painter stalls in the draw issue state.
        busy_hold = 1'b1;
        set_cells(2, 3, 3, 3, 2, 4, 3, 4);
        model_pass(0);
        pulse(1, 0);
        kicks = 0;
        repeat (50) begin
            @(negedge clk);
            if (kick) kicks++;
        end
        chk("t5_hold_nokick", kicks, 0);
        busy_hold = 1'b0;
        @(negedge clk);
        chk("t5_kick_after_release", int'(kick), 1);
        wait_done("t5");

        // Off-board cell is skipped in draw and later in erase.
        set_cells(6, 6, 7, 6, 12, 6, 6, 25);
        model_pass(0);
        pulse(1, 0);
        wait_done("t5b");
        set_cells(1, 1, 2, 1, 3, 1, 4, 1);
        model_pass(0);
        pulse(1, 0);
        wait_done("t5c");

        // Randomized passes with random painter latency.
        lat_lo = 1;
        lat_hi = 4;
        for (int it = 0; it < 14; it++) begin
            piece_color = CW'($urandom);
            bg_color    = CW'($urandom);
            if ($urandom_range(0, 2) == 0)
                set_cells(cx[0], cy[0] + 1, cx[1], cy[1] + 1, cx[2], cy[2] + 1, cx[3], cy[3] + 1);
            else
                set_cells($urandom_range(0, 11), $urandom_range(0, 21), $urandom_range(0, 11),
                          $urandom_range(0, 21), $urandom_range(0, 11), $urandom_range(0, 21),
                          $urandom_range(0, 11), $urandom_range(0, 21));
            clr = ($urandom_range(0, 9) == 0);
            model_pass(clr);
            pulse(!clr, clr);
            wait_done("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
